// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO slice.
package fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 16;

  // Bit positions of the sticky error flags in the packed error word.
  localparam int unsigned ErrOverflow  = 0;
  localparam int unsigned ErrUnderflow = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read strobe interface between the traffic generator (master) and the FIFO (slave).
interface sync_fifo_if import fifo_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DEPTH x DATA_W, with one write port and one registered read port.
module fifo_mem import fifo_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array kept reset-free so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, status flags and the one-cycle read-valid pipeline.
module sync_fifo import fifo_pkg::*; #(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              rd_valid_q;
  logic [1:0]        err_q;
  logic [1:0]        err_d;
  logic              full;
  logic              empty;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = bus.wr_en & ~full;
  assign rd_ok = bus.rd_en & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    err_d = bus.clr_err ? 2'b00 : err_q;
    if (bus.wr_en && full) begin
      err_d[ErrOverflow] = 1'b1;
    end
    if (bus.rd_en && empty) begin
      err_d[ErrUnderflow] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      rd_valid_q <= rd_ok;
      err_q      <= err_d;
    end
  end

  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
  assign bus.count        = count_q;
  assign bus.overflow     = err_q[ErrOverflow];
  assign bus.underflow    = err_q[ErrUnderflow];

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock synchronous FIFO that terminates the write/read strobe interface driven by the FIFO traffic generator. It accepts write beats on wr_en/wr_data and returns data on rd_en with a registered, one-cycle read latency. It reports full/empty, almost-full/almost-empty and occupancy, plus sticky overflow/underflow error flags for bench and debug visibility.

Parameters:
DATA_W, 8, data width in bits
DEPTH, 16, number of entries; power of two, at least 4
AFULL_TH, 14, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset; synchronous, active-high
wr_en  input  1  write strobe, one beat per cycle
wr_data  input  DATA_W  write data, sampled when wr_en=1
rd_en  input  1  read strobe, one beat per cycle
rd_data  output  DATA_W  read data, registered
rd_valid  output  1  one-cycle pulse; rd_data holds the entry from the read accepted in the previous cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. So empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
- Reset has priority over all other inputs. Asserting rst mid-stream drops every stored entry and any pending rd_valid.
- Write acceptance: wr_ok = wr_en & ~full, evaluated on pre-edge state. An accepted write stores wr_data at mem[wr_ptr] and advances wr_ptr.
- Read acceptance: rd_ok = rd_en & ~empty, evaluated on pre-edge state. An accepted read registers mem[rd_ptr] into rd_data and advances rd_ptr. rd_valid=1 on the following cycle only.
- Read latency is one cycle: data appears on the edge after the rd_en cycle.
- When no read is accepted, rd_data holds its last value and rd_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 when wr_ok only
  - -1 when rd_ok only
  - unchanged when both or neither
- Simultaneous write and read:
  - When full: the write is rejected (full is pre-edge) and the read proceeds, so count goes to DEPTH-1.
  - When empty: the read is rejected and the write proceeds; there is no fall-through.
  - Otherwise both are accepted.
- No bypass: a write becomes readable the cycle after it is accepted. empty deasserts the edge after the first write.
- Flags full, empty, almost_full and almost_empty are decoded from the count register. They are registered-equivalent and glitch-free.
- overflow is set on wr_en & full; underflow is set on rd_en & empty. Both remain set until rst or clr_err.
  - clr_err and a new error event in the same cycle: the flag stays set (set wins).
- Rejected operations change no pointer, no count and no stored data.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_W and DEPTH constants
  - function for pointer/count widths (clog2)
  - error-flag bit indices, if packed into a status word
- Sub-module fifo_mem: simple dual-port RAM, DEPTH x DATA_W.
  - One write port: we, waddr, wdata.
  - One registered read port: re, raddr, rdata.
  - Intended to infer block or distributed RAM.
- sync_fifo owns the pointers, count, flags and rd_valid pipeline.

Test Plan:
- Reset, then write 0xAA once, idle 256 cycles, pulse rd_en -> next cycle rd_valid=1, rd_data=0xAA; empty=1 afterwards; count sequence 0,1,0.
- Write 0x00..0x0F back-to-back (16 beats), then a 17th write of 0x55 -> full=1, count=16, overflow=1. Subsequent 16 reads return 0x00..0x0F in order; 0x55 is never returned.
- From empty, pulse rd_en -> underflow=1, rd_valid stays 0, count=0. Pulse clr_err -> underflow=0.
- Preload 5 entries, then assert wr_en and rd_en together for 10 cycles -> count stays 5 throughout and read data is in FIFO order. Repeat at full: count goes 16 -> 15 and overflow=1.
- Pointer wrap: stream 40 writes (values 0..39) interleaved with reads, keeping count between 1 and 15 -> all 40 values are read back in order, with almost_full/almost_empty toggling at 14/2.
- Fill to 8 entries, assert rst for one cycle with wr_en=rd_en=1 -> count=0, empty=1, rd_valid=0 the next cycle, and flags are cleared.
